// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encoding, error codes and header defaults for the UART frame controller.
package uart_frame_pkg;
  typedef enum logic [7:0] {
    S_IDLE     = 8'h01,
    S_HDR1     = 8'h02,
    S_LEN      = 8'h04,
    S_LO       = 8'h08,
    S_HI       = 8'h10,
    S_CHK      = 8'h20,
    S_START    = 8'h40,
    S_WAIT_FFT = 8'h80
  } state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;
  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: counts idle cycles between bytes and flags when the gap reaches TIMEOUT.
module uart_gap_timer #(
  parameter logic [31:0] TIMEOUT = 32'd52070
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !en) ? '0 : cnt + 32'd1;
  assign expire = en && cnt >= TIMEOUT;
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: turns the UART byte stream into checksummed 16-bit sample frames and
// hands each good frame to the FFT, holding off new frames until the FFT is done.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 8,
  parameter int          MAX_SAMPLES = 256,
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter logic [31:0] TIMEOUT     = 32'd52070
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              fft_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              fft_start,
  output logic [ADDR_W:0]   fft_len,
  output logic              busy,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              drop
);
  state_t state, state_nx;
  logic [ADDR_W:0] n, cnt, cnt_nx;
  logic [7:0] lo, acc;
  logic len_ok, chk_ok, tmo, gap_en;
  assign len_ok = int'(rx_data) + 1 <= MAX_SAMPLES;
  assign chk_ok = rx_data == acc;
  assign cnt_nx = cnt + 1'b1;
  uart_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
    .clk(clk), .rst_n(rst_n), .en(gap_en), .clr(rx_done), .expire(tmo)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = state;
    gap_en    = state inside {S_HDR1, S_LEN, S_LO, S_HI, S_CHK};
    busy      = !(state inside {S_IDLE, S_HDR1});
    fft_start = state == S_START;
    if (rx_done)
      case (state)
        S_IDLE:  state_nx = rx_data == HDR0 ? S_HDR1 : S_IDLE;
        S_HDR1:  state_nx = rx_data == HDR1 ? S_LEN : rx_data == HDR0 ? S_HDR1 : S_IDLE;
        S_LEN:   state_nx = len_ok ? S_LO : S_IDLE;
        S_LO:    state_nx = S_HI;
        S_HI:    state_nx = cnt_nx == n ? S_CHK : S_LO;
        S_CHK:   state_nx = chk_ok ? S_START : S_IDLE;
        default: state_nx = state;
      endcase
    else if (tmo) state_nx = S_IDLE;
    if (state == S_START) state_nx = S_WAIT_FFT;
    if (state == S_WAIT_FFT && fft_done) state_nx = S_IDLE;
  end
  // Bytes landing while the FFT owns the buffer are discarded and reported via drop.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      fft_len   <= '0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      drop      <= 1'b0;
      n         <= '0;
      cnt       <= '0;
      lo        <= '0;
      acc       <= '0;
    end else begin
      wr_en     <= rx_done && state == S_HI;
      frame_err <= 1'b0;
      drop      <= 1'b0;
      if (rx_done)
        case (state)
          S_LEN:
            if (len_ok) begin
              n        <= (ADDR_W+1)'({1'b0, rx_data} + 9'd1);
              cnt      <= '0;
              acc      <= rx_data;
              err_code <= ERR_NONE;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end
          S_LO: begin
            lo  <= rx_data;
            acc <= acc ^ rx_data;
          end
          S_HI: begin
            wr_addr <= cnt[ADDR_W-1:0];
            wr_data <= DATA_W'({rx_data, lo});
            cnt     <= cnt_nx;
            acc     <= acc ^ rx_data;
          end
          S_CHK:
            if (chk_ok) fft_len <= n;
            else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
          S_START, S_WAIT_FFT: drop <= 1'b1;
          default: ;
        endcase
      else if (tmo) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
      end
    end
endmodule
